// File: rtl/mac_pkg.sv
// mac_pkg: FSM state encoding and default widths shared by the MAC accumulator block.
package mac_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_CNT_W  = 9;
endpackage

// File: rtl/sat_adder.sv
// sat_adder: acc + zext(prod), pinned at all-ones when the true sum does not fit in ACC_W bits.
module sat_adder #(
    parameter int ACC_W  = 24,
    parameter int PROD_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum_sat,
    output logic              ovf
);
    logic [ACC_W:0] full;
    always_comb begin
        full    = {1'b0, acc} + (ACC_W + 1)'(prod);
        ovf     = full[ACC_W];
        sum_sat = ovf ? '1 : full[ACC_W-1:0];
    end
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates a valid/ready product stream into per-frame saturating sums,
// presenting sum, term count and overflow on a held valid/ready result port.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);
    state_t            state, state_nx;
    logic [ACC_W-1:0]  acc, acc_base, acc_nx;
    logic [CNT_W-1:0]  cnt, cnt_base, cnt_nx;
    logic              ovf, ovf_nx, carry, take;

    // Starting a frame from IDLE is just accumulating onto a zero base.
    sat_adder #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
        .acc(acc_base), .prod(in_prod), .sum_sat(acc_nx), .ovf(carry)
    );

    always_comb begin
        acc_base  = (state == IDLE) ? '0 : acc;
        cnt_base  = (state == IDLE) ? '0 : cnt;
        cnt_nx    = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
        ovf_nx    = (state != IDLE && ovf) || carry;
        in_ready  = (state != HOLD) && !clear;
        out_valid = (state == HOLD);
        take      = in_valid && in_ready;
        state_nx  = state;
        if (take)
            state_nx = in_last ? HOLD : ACCUM;
        else if (state == HOLD && out_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                acc <= acc_nx;
                cnt <= cnt_nx;
                ovf <= ovf_nx;
            end
            // Result registers load only on the final term so they stay put after a handshake.
            if (take && in_last) begin
                out_sum   <= acc_nx;
                out_count <= cnt_nx;
                out_ovf   <= ovf_nx;
            end
        end
    end
endmodule
